// File: rtl/rvv_cmd_queue_pkg.sv
// Shared vector-unit types used by the command path.
package rvv_cmd_queue_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } RVVCmd;

endpackage

// File: rtl/rvv_cmd_queue.sv
// Multi-issue circular command queue between the front end and the vector unit.
// Optional synchronous flush port is enabled by defining RVV_CMD_QUEUE_FLUSH_EN.
module rvv_cmd_queue
    import rvv_cmd_queue_pkg::*;
#(
    parameter int N            = 4,
    parameter int M            = 2,
    parameter int DEPTH        = 16,
    parameter int CAPACITYBITS = $clog2(2*N+1)
) (
    input  logic                      clk,
    input  logic                      rstn,
`ifdef RVV_CMD_QUEUE_FLUSH_EN
    input  logic                      flush_i,
`endif
    input  logic [N-1:0]              enq_valid_i,
    input  RVVCmd [N-1:0]             enq_data_i,
    output logic [CAPACITYBITS-1:0]   capacity_o,
    output logic [M-1:0]              deq_valid_o,
    output RVVCmd [M-1:0]             deq_data_o,
    input  logic [$clog2(M+1)-1:0]    deq_count_i
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int NW  = $clog2(N+1);
    localparam int LIM = (DEPTH < 2*N) ? DEPTH : 2*N;

    RVVCmd         mem [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;

    logic [NW-1:0] enq_n;
    logic [CW:0]   free;
    logic [CW-1:0] room;
    logic [CW-1:0] acc_n;
    logic [CW-1:0] deq_n;

    always_comb begin
        enq_n = '0;
        for (int i = 0; i < N; i++) begin
            enq_n = enq_n + NW'(enq_valid_i[i]);
        end
    end

    // Capacity looks only at registered occupancy; dequeues this cycle are not credited.
    assign free = (CW+1)'(DEPTH) - (CW+1)'(count_q);
    assign room = (free > (CW+1)'(LIM)) ? CW'(LIM) : CW'(free);
    assign capacity_o = CAPACITYBITS'(room);

    always_comb begin
        acc_n = (CW'(enq_n) > room) ? room : CW'(enq_n);
        deq_n = (CW'(deq_count_i) > count_q) ? count_q : CW'(deq_count_i);
`ifdef RVV_CMD_QUEUE_FLUSH_EN
        if (flush_i) begin
            acc_n = '0;
            deq_n = '0;
        end
`endif
    end

    always_comb begin
        for (int j = 0; j < M; j++) begin
            deq_valid_o[j] = CW'(j) < count_q;
            deq_data_o[j]  = mem[rd_q + PW'(j)];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < acc_n) begin
                mem[wr_q + PW'(i)] <= enq_data_i[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
`ifdef RVV_CMD_QUEUE_FLUSH_EN
            if (flush_i) begin
                rd_q    <= wr_q;
                count_q <= '0;
            end else begin
                rd_q    <= rd_q + PW'(deq_n);
                wr_q    <= wr_q + PW'(acc_n);
                count_q <= count_q + acc_n - deq_n;
            end
`else
            rd_q    <= rd_q + PW'(deq_n);
            wr_q    <= wr_q + PW'(acc_n);
            count_q <= count_q + acc_n - deq_n;
`endif
        end
    end

`ifndef SYNTHESIS
    logic [N:0] valid_ext;
    assign valid_ext = {1'b0, enq_valid_i};

    always @(posedge clk) begin
        if (rstn) begin
            assert ((DEPTH & (DEPTH - 1)) == 0)
            else $warning("rvv_cmd_queue: DEPTH %0d is not a power of two", DEPTH);
            assert ((valid_ext & (valid_ext + 1'b1)) == '0)
            else $warning("rvv_cmd_queue: unaligned enq_valid_i %b", enq_valid_i);
            assert (CW'(enq_n) <= room)
            else $warning("rvv_cmd_queue: overflow, enq %0d room %0d", enq_n, room);
            assert (CW'(deq_count_i) <= count_q)
            else $warning("rvv_cmd_queue: underflow, deq %0d count %0d",
                          deq_count_i, count_q);
        end
    end
`endif

endmodule

// File: tb/tb_rvv_cmd_queue.sv
// Directed self-checking bench for rvv_cmd_queue (default parameters).
// Flush steps run only when RVV_CMD_QUEUE_FLUSH_EN is defined.
module tb_rvv_cmd_queue;
    import rvv_cmd_queue_pkg::*;

    logic        clk;
    logic        rstn;
    logic [3:0]  ev;
    RVVCmd [3:0] ed;
    logic [3:0]  cap;
    logic [1:0]  dv;
    RVVCmd [1:0] dd;
    logic [1:0]  dc;
`ifdef RVV_CMD_QUEUE_FLUSH_EN
    logic        flush;
`endif

    int checks = 0;
    int errors = 0;

    rvv_cmd_queue dut (
        .clk         (clk),
        .rstn        (rstn),
`ifdef RVV_CMD_QUEUE_FLUSH_EN
        .flush_i     (flush),
`endif
        .enq_valid_i (ev),
        .enq_data_i  (ed),
        .capacity_o  (cap),
        .deq_valid_o (dv),
        .deq_data_o  (dd),
        .deq_count_i (dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic RVVCmd mk(input int k);
        RVVCmd r;
        r.insn = 32'h1000 + 32'(k);
        r.rs1  = {32'(k), 32'hA5A5_0000};
        r.rs2  = ~{32'(k), 32'(k)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int v, input int c);
        chk({tag, " valid"}, 256'(dv), 256'(v));
        chk({tag, " cap"}, 256'(cap), 256'(c));
    endtask

    task automatic chk_hd(input string tag, input int a, input int b);
        chk({tag, " data0"}, 256'(dd[0]), 256'(mk(a)));
        chk({tag, " data1"}, 256'(dd[1]), 256'(mk(b)));
    endtask

    task automatic enq(input int n, input int base);
        for (int i = 0; i < 4; i++) begin
            ev[i] = (i < n);
            ed[i] = (i < n) ? mk(base + i) : '0;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fill_cap [4];
        fill_cap = '{8, 8, 4, 0};
        rstn = 1'b0;
        dc   = '0;
        enq(0, 0);
`ifdef RVV_CMD_QUEUE_FLUSH_EN
        flush = 1'b0;
`endif
        #3;
        chk_st("reset", 0, 8);
        step;
        step;
        rstn = 1'b1;

        // ordering
        enq(4, 1);
        step;
        chk_st("order", 3, 8);
        chk_hd("order", 1, 2);
        enq(0, 0);
        dc = 2'd2;
        step;
        chk_st("order2", 3, 8);
        chk_hd("order2", 3, 4);
        step;
        chk_st("empty", 0, 8);

        // fill to full
        dc = 2'd0;
        for (int k = 0; k < 4; k++) begin
            enq(4, 16 + 4*k);
            step;
            chk("fill cap", 256'(cap), 256'(fill_cap[k]));
        end
        chk_st("full", 3, 0);
        chk_hd("full", 16, 17);
        enq(4, 40);
        step;
        chk_st("overflow", 3, 0);
        chk_hd("overflow", 16, 17);

        // dequeue at full
        enq(0, 0);
        dc = 2'd2;
        step;
        chk_st("full_deq", 3, 2);
        chk_hd("full_deq", 18, 19);
        for (int k = 0; k < 6; k++) begin
            step;
            chk_hd("drain", 20 + 2*k, 21 + 2*k);
        end
        step;
        chk_st("drained", 0, 8);

        // move both pointers to 14
        dc = 2'd0;
        enq(4, 50);
        step;
        enq(4, 54);
        step;
        enq(2, 58);
        step;
        chk_st("pre_wrap", 3, 6);
        enq(0, 0);
        dc = 2'd2;
        repeat (5) step;
        chk_st("pre_wrap_empty", 0, 8);

        // wrap-around
        dc = 2'd0;
        enq(4, 60);
        step;
        chk_st("wrap", 3, 8);
        chk_hd("wrap", 60, 61);
        enq(0, 0);
        dc = 2'd2;
        step;
        chk_hd("wrap2", 62, 63);
        step;
        chk_st("wrap_empty", 0, 8);

        // underflow clamp
        dc = 2'd0;
        enq(1, 70);
        step;
        chk_st("uf_pre", 1, 8);
        chk("uf_pre data0", 256'(dd[0]), 256'(mk(70)));
        enq(0, 0);
        dc = 2'd2;
        step;
        chk_st("underflow", 0, 8);
        dc = 2'd0;
        enq(2, 71);
        step;
        chk_st("uf_post", 3, 8);
        chk_hd("uf_post", 71, 72);

        // simultaneous enq and deq
        enq(2, 73);
        dc = 2'd1;
        step;
        chk_st("simul", 3, 8);
        chk_hd("simul", 72, 73);

`ifdef RVV_CMD_QUEUE_FLUSH_EN
        dc = 2'd0;
        enq(4, 75);
        step;
        enq(3, 79);
        step;
        chk_st("pre_flush", 3, 6);
        flush = 1'b1;
        enq(4, 90);
        dc = 2'd2;
        step;
        flush = 1'b0;
        chk_st("flush", 0, 8);
        enq(1, 95);
        dc = 2'd0;
        step;
        chk_st("post_flush", 1, 8);
        chk("post_flush data0", 256'(dd[0]), 256'(mk(95)));
`endif

        // asynchronous reset mid-operation
        dc = 2'd0;
        enq(2, 100);
        step;
        chk("pre_rst valid", 256'(dv), 256'(3));
        enq(0, 0);
        rstn = 1'b0;
        #1;
        chk_st("async_rst", 0, 8);
        step;
        rstn = 1'b1;
        step;
        chk_st("post_rst", 0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvv_cmd_queue.md
RVV_CMD_QUEUE -- requirements
Module: rvv_cmd_queue

Interface
REQ-001 SHALL have parameter N, default 4: enqueue width, matching the front-end command width.
REQ-002 SHALL have parameter M, default 2: dequeue width.
REQ-003 SHALL have parameter DEPTH, default 16: entry count, power of two, at least 2*N.
REQ-004 SHALL have parameter CAPACITYBITS, default $clog2(2*N+1): capacity port width.
REQ-005 SHALL have the following ports, clock and reset first:
- clk  input  1  clock.
- rstn  input  1  reset; asynchronous, active-low.
- enq_valid_i  input  N  aligned command valids.
- enq_data_i  input  N x RVVCmd  commands.
- capacity_o  output  CAPACITYBITS  entries enqueuable this cycle.
- deq_valid_o  output  M  aligned head valids.
- deq_data_o  output  M x RVVCmd  head commands, oldest at index 0.
- deq_count_i  input  $clog2(M+1)  number of head entries consumed this cycle.

Function
REQ-006 SHALL hold a circular buffer of DEPTH RVVCmd entries with a read pointer rd_q, a write pointer wr_q, and an occupancy count_q of $clog2(DEPTH+1) bits.
REQ-007 SHALL compute enq_n as the popcount of enq_valid_i; the input is aligned, so valids form a contiguous prefix starting at index 0.
REQ-008 SHALL write enq_data_i[i] to mem[(wr_q+i) mod DEPTH] for every i < enq_n, then set wr_q to wr_q+enq_n mod DEPTH.
REQ-009 SHALL drive capacity_o = min(DEPTH-count_q, 2*N), taken from registered state only.
REQ-010 SHALL not credit same-cycle dequeues into capacity_o.
REQ-011 SHALL drive deq_valid_o[j] = (j < count_q), and deq_data_o[j] = mem[(rd_q+j) mod DEPTH].
REQ-012 SHALL set rd_q to rd_q+deq_n mod DEPTH, where deq_n = min(deq_count_i, count_q).
REQ-013 SHALL update count_q to count_q + enq_n - deq_n each cycle; simultaneous enqueue and dequeue are legal, including when full or empty.
REQ-014 SHALL have an enqueue-to-visible latency of exactly 1 cycle, with no same-cycle bypass from enq to deq.
REQ-015 SHALL, on overflow (enq_n > capacity_o), accept only the first capacity_o entries and discard the rest; overflow is a protocol violation.
REQ-016 SHALL, on underflow (deq_count_i > count_q), clamp as in REQ-012; underflow is a protocol violation.
REQ-017 SHALL handle pointer wrap-around modulo DEPTH for any enq_n or deq_n straddling index DEPTH-1.

Reset
REQ-018 SHALL, during reset, set rd_q=0, wr_q=0, count_q=0.
REQ-019 SHALL therefore reset deq_valid_o to all zero and capacity_o to min(DEPTH, 2*N), which is 8 with default parameters.
REQ-020 SHALL not reset mem; deq_data_o is don't-care while its valid is low.
REQ-021 SHALL, on reset asserted mid-operation, discard all entries immediately.

Configuration
REQ-022 SHALL, when RVV_CMD_QUEUE_FLUSH_EN is defined, add input flush_i (1 bit).
REQ-023 SHALL, on a cycle with flush_i=1, set the next state to rd_q=wr_q, count_q=0, and ignore that cycle's enqueues and dequeues.
REQ-024 SHALL, with flush_i=1, show capacity_o=min(DEPTH,2*N) and deq_valid_o=0 on the following cycle.
REQ-025 SHALL, when RVV_CMD_QUEUE_FLUSH_EN is undefined, have no flush_i port and no flush logic.

Structure
REQ-026 SHALL take RVVCmd from the shared rvv package.
REQ-027 SHALL keep no new shared typedefs; count and pointer widths are local parameters.
REQ-028 SHALL be a single module with no sub-module; the storage is a flop array.
REQ-029 SHALL include non-synthesis assertions for:
- unaligned enq_valid_i;
- enq_n > capacity_o;
- deq_count_i > count_q;
- DEPTH not a power of two.

Verification
REQ-030 SHALL cover reset: after reset, capacity_o=8 and deq_valid_o=00.
REQ-031 SHALL cover enqueue/dequeue ordering:
- enqueue 4 commands A..D with deq_count_i=0;
- next cycle: deq_valid_o=11, deq_data_o={A,B}, capacity_o=8 (12 free, clamped);
- dequeue 2: the following cycle shows {C,D}.
REQ-032 SHALL cover fill to full:
- enqueue 4 per cycle for 4 cycles, with no dequeue;
- capacity_o steps 8,8,8,4,0;
- count_q=16; a further enq_valid_i=1111 with capacity_o=0 writes nothing and fires the assertion.
REQ-033 SHALL cover simultaneous enqueue and dequeue at full: count_q=16, with enq of 0 and deq_count_i=2, gives next capacity_o=2 and data order preserved.
REQ-034 SHALL cover wrap-around:
- with rd_q=wr_q=14 and empty, enqueue E0..E3;
- entries land at 14,15,0,1;
- dequeue 2 per cycle yields {E0,E1} then {E2,E3}.
REQ-035 SHALL cover underflow and flush:
- with count_q=1 and deq_count_i=2, only 1 entry is consumed and count_q becomes 0;
- with RVV_CMD_QUEUE_FLUSH_EN, flush_i at count_q=10 together with enq 1111 gives count_q=0 and capacity_o=8 next cycle.
